// File: rtl/pt2262_tx_scheduler.sv
// Round-robin scheduler sharing one PT2262 encoder between N_REQ requesters.
// Optional watchdog on missing sync edges: define PT2262_SCHED_WDOG_EN.
module pt2262_tx_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned REPEATS      = 4,
  parameter int unsigned RST_HOLD_CYC = 500,
  parameter int unsigned SYNC_GAP_CYC = 31000,
  parameter int unsigned WDOG_CYC     = 262144
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [4*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic                 busy,
  output logic                 enc_reset,
  output logic [7:0]           enc_A,
  output logic [3:0]           enc_D,
  input  logic                 enc_sync
);

  localparam int unsigned HOLD_GAP_MAX = (RST_HOLD_CYC > SYNC_GAP_CYC) ? RST_HOLD_CYC : SYNC_GAP_CYC;
  localparam int unsigned CNT_MAX      = (WDOG_CYC > HOLD_GAP_MAX) ? WDOG_CYC : HOLD_GAP_MAX;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W        = $clog2(N_REQ);
  localparam int unsigned WC_W         = $clog2(REPEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_RUN, S_GAP, S_DONE, S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [7:0]         enc_a_q, enc_a_d;
  logic [3:0]         enc_d_q, enc_d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [2:0]         sync_q;
  logic               sync_rise;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   cand_idx;
  int unsigned        cand;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge flop
  assign sync_rise = sync_q[1] & ~sync_q[2];

  // First set request searching upward from ptr_q, wrapping at N_REQ
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = PTR_W'(cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      grant_q    <= '0;
      enc_a_q    <= '0;
      enc_d_q    <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      grant_q    <= grant_d;
      enc_a_q    <= enc_a_d;
      enc_d_q    <= enc_d_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      sync_q     <= {sync_q[1:0], enc_sync};
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    grant_d    = grant_q;
    enc_a_d    = enc_a_q;
    enc_d_d    = enc_d_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          state_d          = S_LOAD;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          win_d            = arb_idx;
          enc_a_d          = req_addr[{arb_idx, 3'b000} +: 8];
          enc_d_d          = req_data[{arb_idx, 2'b00} +: 4];
          cnt_d            = '0;
          word_cnt_d       = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(RST_HOLD_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (sync_rise) begin
          cnt_d      = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WC_W'(REPEATS - 1)) state_d = S_GAP;
        end
`ifdef PT2262_SCHED_WDOG_EN
        else if (cnt_q == CNT_W'(WDOG_CYC - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(SYNC_GAP_CYC - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE, S_ABORT: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant     = grant_q;
    enc_A     = enc_a_q;
    enc_D     = enc_d_q;
    busy      = (state_q != S_IDLE);
    enc_reset = !((state_q == S_RUN) || (state_q == S_GAP));
    done      = (state_q == S_DONE) ? grant_q : '0;
`ifdef PT2262_SCHED_WDOG_EN
    err       = (state_q == S_ABORT);
`else
    err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Directed self-checking bench for pt2262_tx_scheduler with shortened timing parameters.
`timescale 1ns/1ps
module tb_pt2262_tx_scheduler;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned REPEATS  = 4;
  localparam int unsigned RST_HOLD = 10;
  localparam int unsigned GAP      = 20;
  localparam int unsigned WDOG     = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  grant, done;
  logic        err, busy, enc_reset, enc_sync;
  logic [7:0]  enc_A;
  logic [3:0]  enc_D;

  logic [31:0] addr_tab = 32'hC35AA53C;
  logic [15:0] data_tab = 16'hE396;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  pt2262_tx_scheduler #(
    .N_REQ(N_REQ), .REPEATS(REPEATS), .RST_HOLD_CYC(RST_HOLD),
    .SYNC_GAP_CYC(GAP), .WDOG_CYC(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .busy(busy), .enc_reset(enc_reset),
    .enc_A(enc_A), .enc_D(enc_D), .enc_sync(enc_sync)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync_pulse();
    enc_sync = 1'b1;
    tick(3);
    enc_sync = 1'b0;
    tick(5);
  endtask

  // Starts with the DUT in IDLE and req already set; ends back in IDLE.
  task automatic txn(input string tag, input int unsigned idx, input logic [3:0] req_after);
    logic [3:0] g;
    logic [7:0] ea;
    logic [3:0] ed;
    g = '0;
    g[idx] = 1'b1;
    ea = addr_tab[idx*8 +: 8];
    ed = data_tab[idx*4 +: 4];
    tick(1);
    chk({tag, ":arb_busy"}, busy, 1);
    chk({tag, ":arb_grant"}, grant, 0);
    tick(1);
    chk({tag, ":grant"}, grant, g);
    chk({tag, ":enc_A"}, enc_A, ea);
    chk({tag, ":enc_D"}, enc_D, ed);
    chk({tag, ":load_reset"}, enc_reset, 1);
    req = req_after;
    req_addr = ~addr_tab;
    req_data = ~data_tab;
    tick(RST_HOLD - 1);
    chk({tag, ":hold_last"}, enc_reset, 1);
    tick(1);
    chk({tag, ":run_reset"}, enc_reset, 0);
    repeat (REPEATS - 1) sync_pulse();
    chk({tag, ":mid_busy"}, busy, 1);
    chk({tag, ":mid_done"}, done, 0);
    enc_sync = 1'b1;
    tick(3);
    enc_sync = 1'b0;
    tick(GAP - 1);
    chk({tag, ":gap_done"}, done, 0);
    tick(1);
    chk({tag, ":done"}, done, g);
    chk({tag, ":done_reset"}, enc_reset, 1);
    chk({tag, ":done_grant"}, grant, g);
    chk({tag, ":held_A"}, enc_A, ea);
    chk({tag, ":held_D"}, enc_D, ed);
    req_addr = addr_tab;
    req_data = data_tab;
    tick(1);
    chk({tag, ":post_done"}, done, 0);
    chk({tag, ":post_grant"}, grant, 0);
    chk({tag, ":post_busy"}, busy, 0);
  endtask

  initial begin
    enc_sync = 1'b0;
    req_addr = addr_tab;
    req_data = data_tab;
    tick(2);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enc_reset", enc_reset, 1);
    chk("rst_enc_A", enc_A, 0);
    chk("rst_enc_D", enc_D, 0);
    rst = 1'b1;
    tick(1);
    chk("idle_busy", busy, 0);

    req = 4'b0010;
    txn("single", 1, 4'b0000);

    // Pointer is now 2: only requester 0 pending exercises the wrap.
    req = 4'b0001;
    tick(2);
    chk("wrap_grant", grant, 4'b0001);
    tick(RST_HOLD);
    chk("mr_run", enc_reset, 0);
    sync_pulse();
    sync_pulse();
    rst = 1'b0;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_enc_reset", enc_reset, 1);
    chk("mr_enc_A", enc_A, 0);
    chk("mr_enc_D", enc_D, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    tick(2);
    chk("mr_hold_done", done, 0);
    rst = 1'b1;
    txn("rerun", 0, 4'b0000);

    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    req = 4'b1111;
    txn("rr0", 0, 4'b1111);
    txn("rr1", 1, 4'b1111);
    txn("rr2", 2, 4'b1111);
    txn("rr3", 3, 4'b0001);

    txn("fair0", 0, 4'b0101);
    txn("fair2", 2, 4'b0101);
    txn("fair0b", 0, 4'b0000);

    req = 4'b1000;
    tick(2);
    chk("wd_grant", grant, 4'b1000);
    req = 4'b0000;
    tick(RST_HOLD);
    chk("wd_run", enc_reset, 0);
    tick(WDOG - 1);
    chk("wd_pre_err", err, 0);
    chk("wd_pre_busy", busy, 1);
    tick(1);
`ifdef PT2262_SCHED_WDOG_EN
    chk("wd_err", err, 1);
    chk("wd_abort_grant", grant, 4'b1000);
    chk("wd_abort_done", done, 0);
    tick(1);
    chk("wd_err_clr", err, 0);
    chk("wd_grant_clr", grant, 0);
    chk("wd_busy_clr", busy, 0);
    chk("wd_enc_reset", enc_reset, 1);
    req = 4'b1001;
    tick(2);
    chk("wd_ptr_adv", grant, 4'b0001);
`else
    chk("nowd_err", err, 0);
    chk("nowd_busy", busy, 1);
    chk("nowd_enc_reset", enc_reset, 0);
    tick(500);
    chk("nowd_err_late", err, 0);
    chk("nowd_busy_late", busy, 1);
    chk("nowd_grant_late", grant, 4'b1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pt2262_tx_scheduler.md
# pt2262_tx_scheduler

- Shares one PT2262 encoder between `N_REQ` requesters; each requester supplies an 8-bit address and a 4-bit data nibble.
- Arbitrates round-robin, loads the winner's word into the encoder, and releases the encoder from reset.
- Counts `REPEATS` transmitted code words by watching the encoder's `sync` output, lets the final sync gap finish, then parks the encoder in reset and signals completion.
- Sits between the application request logic and the encoder, all in the encoder's 3 MHz `clk` domain.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `REPEATS`, 4: code words sent per transaction, ≥1.
- `RST_HOLD_CYC`, 500: `clk` cycles `enc_reset` stays high after load (2 oscillator periods).
- `SYNC_GAP_CYC`, 31000: `clk` cycles waited after the last sync rising edge (sync low period).
- `WDOG_CYC`, 262144: watchdog limit between sync edges (only with `PT2262_SCHED_WDOG_EN`).

Ports:
- `clk`  in  1  system clock, 3 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request, one bit per requester.
- `req_addr`  in  8*N_REQ  address of requester i in bits [8i+7:8i].
- `req_data`  in  4*N_REQ  data of requester i in bits [4i+3:4i].
- `grant`  out  N_REQ  one-hot; held for the whole transaction.
- `done`  out  N_REQ  one-cycle pulse on the winner's bit at normal completion.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `busy`  out  1  high from ARB through DONE/ABORT.
- `enc_reset`  out  1  encoder reset, active-high.
- `enc_A`  out  8  encoder address.
- `enc_D`  out  4  encoder data.
- `enc_sync`  in  1  encoder `sync` output (asynchronous to the FSM; synchronised internally).

## Operation
Reset values (`rst` low, asynchronous):
- state IDLE; `grant`, `done`, `err`, `busy` = 0.
- `enc_reset` = 1; `enc_A` = 0; `enc_D` = 0.
- round-robin pointer `ptr` = 0; all counters 0.

FSM states: IDLE, ARB, LOAD, RUN, GAP, DONE, ABORT.
- **IDLE:** if any `req` bit is high, go to ARB.
- **ARB:**
  - Winner = first set `req` bit searching upward from `ptr`, wrapping at `N_REQ`.
  - Register `grant`; latch the winner's `req_addr` slice into `enc_A` and its `req_data` slice into `enc_D`.
  - If `req` has dropped to 0 by this cycle, return to IDLE with no grant.
- **LOAD:** `enc_reset` = 1 for `RST_HOLD_CYC` cycles, then go to RUN.
- **RUN:**
  - `enc_reset` = 0.
  - `enc_sync` passes through a 2-flop synchroniser plus an edge flop.
  - Each rising edge increments `word_cnt`, width $clog2(REPEATS+1).
  - When `word_cnt` reaches `REPEATS`, go to GAP.
- **GAP:** `enc_reset` stays 0; count `SYNC_GAP_CYC` cycles, then go to DONE.
- **DONE (1 cycle):**
  - `done[winner]` = 1; `enc_reset` = 1.
  - `ptr` = (winner+1) mod `N_REQ`.
  - Next cycle: `grant` = 0, `busy` = 0, return to IDLE.
- **ABORT (1 cycle):** same as DONE, but `err` = 1 and `done` stays 0.

Boundary conditions:
- `enc_A` and `enc_D` stay constant from ARB until the next ARB; changes on `req_*` mid-transaction are ignored.
- A requester dropping `req` mid-transaction does not stop the transaction.
- A request still held after its `done` is re-arbitrated; round-robin serves every other pending requester first.
- Several requests arriving in the same cycle: only the `ptr`-priority winner is granted; the others wait.
- `rst` low mid-transaction: immediate return to reset values, with no `done` and no `err` pulse.

## Timing
- First `req` high at IDLE → `grant` and `enc_A`/`enc_D` valid 2 cycles later (IDLE→ARB→LOAD edge).
- `enc_reset` falls `RST_HOLD_CYC` cycles after entering LOAD.
- Rising edge of `enc_sync` → `word_cnt` increments 3 cycles later.
- Last sync edge → `done` pulse `SYNC_GAP_CYC`+1 cycles after the detected edge.
- `done` → earliest next `grant` is 3 cycles later (DONE, IDLE, ARB).
- One code word with the default encoder is about 128000 `clk` cycles.

## Configuration
Macro: `PT2262_SCHED_WDOG_EN`.
- **Defined:**
  - In RUN, a counter restarts on entry and on every sync rising edge.
  - Reaching `WDOG_CYC` → ABORT.
- **Undefined:**
  - No watchdog counter; `err` is tied to 0.
  - RUN waits indefinitely for sync edges.

## Test plan
- **Single request, defaults:**
  - Stimulus: `req`=4'b0010, addr 8'hA5, data 4'h9.
  - Response: `grant`=4'b0010; `enc_A`=8'hA5, `enc_D`=4'h9; exactly 4 sync edges; one `done[1]` pulse 31001 cycles after the 4th detected edge; `enc_reset` returns to 1.
- **All four requesting simultaneously from reset:** grants in order 0,1,2,3, each followed by its own `done`, with no overlap.
- **Fairness:** `req[0]` held permanently while `req[2]` asserts during req0's transaction → next grant is 2, then 0.
- **Reset mid-RUN:** `rst` low after 2 sync edges → outputs return to reset values within the same cycle; no `done`; a new request afterwards sends a full 4 words.
- **Watchdog (macro defined):**
  - Stimulus: `WDOG_CYC`=1000, `enc_sync` held 0.
  - Response: `err` pulse 1000 cycles after RUN entry; `grant` cleared; `ptr` advanced.
- **Watchdog (macro undefined):** same stimulus → stays in RUN; `err` stays 0.
